// File: rtl/math_exp2_64_if.sv
// Handshake bundle for math_exp2_64: log2 codes flow in, linear magnitudes flow out.
interface math_exp2_64_if;
    logic        in_valid;
    logic        in_ready;
    logic [9:0]  din;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] dout;

    modport master (
        output in_valid,
        output din,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  dout
    );

    modport slave (
        input  in_valid,
        input  din,
        input  out_ready,
        output in_ready,
        output out_valid,
        output dout
    );
endinterface

// File: rtl/math_exp2_64.sv
// Three-stage base-2 antilog: 6.4 fixed-point log2 code to a 64-bit linear magnitude,
// computed as floor(M[f] * 2^e / 256) with bubble-collapsing valid/ready flow control.
module math_exp2_64 (
    input  logic          clk,
    input  logic          rst,
    math_exp2_64_if.slave bus
);
    localparam int DATA_W = 64;
    localparam int COEF_W = 9;
    localparam int STAGES = 3;
    localparam int EXP_W  = 6;
    localparam int FRAC_W = 4;
    localparam int PROD_W = DATA_W + 8;

    // Mantissa table: round(256 * 2^(f/16)), so 256 represents 1.0.
    function automatic logic [COEF_W-1:0] mant_lut(input logic [FRAC_W-1:0] f);
        logic [COEF_W-1:0] m;
        m = '0;
        case (f)
            4'd0:  m = 9'd256;
            4'd1:  m = 9'd267;
            4'd2:  m = 9'd279;
            4'd3:  m = 9'd292;
            4'd4:  m = 9'd304;
            4'd5:  m = 9'd318;
            4'd6:  m = 9'd332;
            4'd7:  m = 9'd347;
            4'd8:  m = 9'd362;
            4'd9:  m = 9'd378;
            4'd10: m = 9'd395;
            4'd11: m = 9'd412;
            4'd12: m = 9'd431;
            4'd13: m = 9'd450;
            4'd14: m = 9'd470;
            4'd15: m = 9'd490;
            default: m = '0;
        endcase
        return m;
    endfunction

    function automatic logic [PROD_W-1:0] shift_mant(input logic [COEF_W-1:0] m,
                                                     input logic [EXP_W-1:0]  e);
        return PROD_W'(m) << e;
    endfunction

    // Dropping the 8 fraction bits truncates toward zero; 490 << 63 still fits in 72 bits.
    function automatic logic [DATA_W-1:0] trunc_prod(input logic [PROD_W-1:0] p);
        return DATA_W'(p >> 8);
    endfunction

    logic adv_p1;
    logic adv_p2;
    logic adv_p3;

    logic              vld_p1_q,  vld_p1_d;
    logic [EXP_W-1:0]  exp_p1_q,  exp_p1_d;
    logic [COEF_W-1:0] mant_p1_q, mant_p1_d;
    logic              vld_p2_q,  vld_p2_d;
    logic [PROD_W-1:0] prod_p2_q, prod_p2_d;
    logic              vld_p3_q,  vld_p3_d;
    logic [DATA_W-1:0] dout_p3_q, dout_p3_d;

    // A stage may load when it is empty or the stage after it is moving.
    always_comb begin
        adv_p3 = bus.out_ready | ~vld_p3_q;
        adv_p2 = adv_p3 | ~vld_p2_q;
        adv_p1 = adv_p2 | ~vld_p1_q;
    end

    always_comb begin
        vld_p1_d  = vld_p1_q;
        exp_p1_d  = exp_p1_q;
        mant_p1_d = mant_p1_q;
        vld_p2_d  = vld_p2_q;
        prod_p2_d = prod_p2_q;
        vld_p3_d  = vld_p3_q;
        dout_p3_d = dout_p3_q;

        // p1: capture exponent and table mantissa
        if (adv_p1) begin
            vld_p1_d = bus.in_valid;
            if (bus.in_valid) begin
                exp_p1_d  = bus.din[FRAC_W +: EXP_W];
                mant_p1_d = mant_lut(bus.din[FRAC_W-1:0]);
            end
        end

        // p2: barrel shift into the full-width product
        if (adv_p2) begin
            vld_p2_d = vld_p1_q;
            if (vld_p1_q) begin
                prod_p2_d = shift_mant(mant_p1_q, exp_p1_q);
            end
        end

        // p3: scale back by 1/256; data only moves on a real item so dout holds when idle
        if (adv_p3) begin
            vld_p3_d = vld_p2_q;
            if (vld_p2_q) begin
                dout_p3_d = trunc_prod(prod_p2_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q  <= 1'b0;
            exp_p1_q  <= '0;
            mant_p1_q <= '0;
            vld_p2_q  <= 1'b0;
            prod_p2_q <= '0;
            vld_p3_q  <= 1'b0;
            dout_p3_q <= '0;
        end else begin
            vld_p1_q  <= vld_p1_d;
            exp_p1_q  <= exp_p1_d;
            mant_p1_q <= mant_p1_d;
            vld_p2_q  <= vld_p2_d;
            prod_p2_q <= prod_p2_d;
            vld_p3_q  <= vld_p3_d;
            dout_p3_q <= dout_p3_d;
        end
    end

    assign bus.in_ready  = adv_p1;
    assign bus.out_valid = vld_p3_q;
    assign bus.dout      = dout_p3_q;

endmodule

// File: tb/tb_math_exp2_64.sv
// Directed and streaming bench for math_exp2_64 with a reference model and in-order scoreboard.
module tb_math_exp2_64;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;

    math_exp2_64_if bus();

    math_exp2_64 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_in     = 0;
    int n_out    = 0;
    logic [63:0] sb_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference built from the mantissa table with separate up/down scaling paths.
    function automatic logic [63:0] ref_exp2(input logic [9:0] d);
        logic [8:0] mt [16];
        logic [5:0] e;
        logic [63:0] m;
        mt = '{9'd256, 9'd267, 9'd279, 9'd292, 9'd304, 9'd318, 9'd332, 9'd347,
               9'd362, 9'd378, 9'd395, 9'd412, 9'd431, 9'd450, 9'd470, 9'd490};
        e = d[9:4];
        m = 64'(mt[d[3:0]]);
        if (e >= 6'd8) return m << (e - 6'd8);
        else           return m >> (6'd8 - e);
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Output monitor: scoreboard on transfers, stability while stalled.
    initial begin
        logic        stall_prev;
        logic [63:0] dout_prev;
        logic [63:0] exp_v;
        stall_prev = 1'b0;
        dout_prev  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb_q.delete();
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("stall_vld", 64'(bus.out_valid), 64'd1);
                    check("stall_dout", bus.dout, dout_prev);
                end
                if (bus.out_valid && bus.out_ready) begin
                    n_out++;
                    check("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
                    if (sb_q.size() != 0) begin
                        exp_v = sb_q.pop_front();
                        check("sb_data", bus.dout, exp_v);
                    end
                end
                if (bus.in_valid && bus.in_ready) begin
                    n_in++;
                    sb_q.push_back(ref_exp2(bus.din));
                end
                stall_prev = bus.out_valid & ~bus.out_ready;
                dout_prev  = bus.dout;
            end
        end
    end

    task automatic push_item(input logic [9:0] d);
        int   guard;
        logic acc;
        guard = 0;
        bus.din      = d;
        bus.in_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!acc && guard < 200);
        check("push_acc", 64'(acc), 64'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_one(input logic [9:0] d, input logic [63:0] exp, input string tag);
        int lat;
        push_item(d);
        lat = 0;
        while (lat < 20) begin
            if (lat > 0) @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus.out_valid) break;
        end
        check({tag, "_lat"}, 64'(lat), 64'd3);
        check({tag, "_val"}, bus.dout, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int c0;
        int n0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.din       = '0;
        bus.out_ready = 1'b1;
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_dout", bus.dout, 64'd0);
        @(posedge clk);
        #1;

        // Basic and extreme directed codes.
        send_one({6'd0, 4'd0},   64'd1,                  "e0f0");
        send_one({6'd10, 4'd8},  64'd1448,               "e10f8");
        send_one({6'd8, 4'd0},   64'd256,                "e8f0");
        send_one({6'd0, 4'd15},  64'd1,                  "e0f15");
        send_one({6'd63, 4'd15}, 64'hF500_0000_0000_0000, "e63f15");
        send_one({6'd63, 4'd0},  64'h8000_0000_0000_0000, "e63f0");
        send_one({6'd9, 4'd3},   64'd584,                "e9f3");

        // All codes back to back.
        c0 = cyc;
        n0 = n_out;
        for (int i = 0; i < 1024; i++) push_item(10'(i));
        check("stream_cycles", 64'(cyc - c0), 64'd1024);
        idle(6);
        check("stream_outputs", 64'(n_out - n0), 64'd1024);
        check("stream_drained", 64'(sb_q.size()), 64'd0);

        // Back-pressure: three items fill the pipe, then hold.
        bus.out_ready = 1'b0;
        push_item({6'd20, 4'd1});
        push_item({6'd21, 4'd2});
        push_item({6'd22, 4'd3});
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.din      = {6'd23, 4'd4};
            @(negedge clk);
            check("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
            check("bp_out_valid", 64'(bus.out_valid), 64'd1);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        idle(6);
        check("bp_drained", 64'(sb_q.size()), 64'd0);

        // Random valid/ready traffic.
        n0 = n_in;
        c0 = cyc;
        while ((n_in - n0) < 10000 && (cyc - c0) < 60000) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.din       = 10'($urandom_range(0, 1023));
            bus.out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        check("rand_items", 64'((n_in - n0) >= 10000), 64'd1);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        idle(6);
        check("rand_drained", 64'(sb_q.size()), 64'd0);

        // Reset with three items in flight.
        bus.out_ready = 1'b0;
        push_item({6'd30, 4'd5});
        push_item({6'd31, 4'd6});
        push_item({6'd32, 4'd7});
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send_one({6'd1, 4'd0}, 64'd2, "post_rst");
        idle(4);
        check("post_rst_drained", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
